// File: rtl/danmaku_pkg.sv
// Shared types and default geometry for the danmaku overlay frame fetcher.
package danmaku_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WORD_BYTES          = 8;
    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_WORDS_PER_FRAME = 19200;
    localparam int DEF_BURST_LEN       = 8;
    localparam int DEF_FIFO_DEPTH      = 256;
    localparam int DEF_USEDW_W         = 8;

endpackage

// File: rtl/danmaku_frame_fetcher_if.sv
// Avalon-MM burst read bus between the frame fetcher and the SDRAM interconnect.
interface danmaku_frame_fetcher_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic [6:0]        burstcount;
    logic              waitrequest;
    logic [63:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/danmaku_frame_fetcher.sv
// Fetches one frame of packed pixel words per frame_start via credit-throttled
// Avalon burst reads and passes returned words straight to the adapter FIFO.
//
// state | meaning
// IDLE  | waiting for frame_start with enable
// ISSUE | launching bursts while the FIFO has credit
// DRAIN | all bursts accepted, waiting for the last returned word
module danmaku_frame_fetcher
    import danmaku_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int WORDS_PER_FRAME = DEF_WORDS_PER_FRAME,
    parameter int BURST_LEN       = DEF_BURST_LEN,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int USEDW_W         = DEF_USEDW_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    frame_start,
    input  logic [ADDR_W-1:0]       fb_base,
    danmaku_frame_fetcher_if.master avm,
    input  logic [USEDW_W-1:0]      fifo_wrusedw,
    output logic [63:0]             data_src,
    output logic                    valid_src,
    input  logic                    ready_src,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err_overrun,
    output logic                    err_overflow
);

    localparam int CNT_W  = $clog2(WORDS_PER_FRAME + 1);
    localparam int OUT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int MAX_W  = (USEDW_W > OUT_W) ? USEDW_W : OUT_W;
    // two extra bits: three-term sum must never wrap before the compare
    localparam int CRED_W = ((MAX_W > 7) ? MAX_W : 7) + 2;
    localparam logic [CNT_W-1:0] WPF = CNT_W'(WORDS_PER_FRAME);

    function automatic logic [6:0] burst_of(input logic [CNT_W-1:0] issued);
        logic [CNT_W-1:0] left;
        left = WPF - issued;
        if (int'(left) > BURST_LEN) return 7'(BURST_LEN);
        else                        return 7'(left);
    endfunction

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    issued_q;
    logic [OUT_W-1:0]    outstanding_q, outstanding_nxt;
    logic                pend_q;
    logic [6:0]          burst;
    logic                credit_ok;
    logic                cmd_read;
    logic                accept;
    logic                start;
    logic                dec;

    always_comb begin
        burst     = burst_of(issued_q);
        credit_ok = (CRED_W'(fifo_wrusedw) + CRED_W'(outstanding_q) + CRED_W'(burst))
                    <= CRED_W'(FIFO_DEPTH);
        // once asserted the command holds until accepted, regardless of credit
        cmd_read  = pend_q || (state == ISSUE && credit_ok);
        accept    = cmd_read && !avm.waitrequest;
        start     = (state == IDLE) && frame_start && enable;
        dec       = avm.readdatavalid && (outstanding_q != '0);
    end

    assign avm.read       = cmd_read;
    assign avm.address    = cmd_read ? addr_q : '0;
    assign avm.burstcount = cmd_read ? burst  : 7'd0;

    assign data_src  = avm.readdata;
    assign valid_src = avm.readdatavalid;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (accept && (issued_q + CNT_W'(burst) == WPF)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (outstanding_q == '0) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        outstanding_nxt = outstanding_q;
        if (start) begin
            outstanding_nxt = '0;
        end else begin
            if (accept) outstanding_nxt = outstanding_nxt + OUT_W'(burst);
            if (dec)    outstanding_nxt = outstanding_nxt - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            pend_q        <= 1'b0;
            err_overrun   <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            state         <= state_nxt;
            outstanding_q <= outstanding_nxt;
            pend_q        <= cmd_read && avm.waitrequest;
            if (start) begin
                addr_q   <= fb_base;
                issued_q <= '0;
            end else if (accept) begin
                addr_q   <= addr_q + ADDR_W'(burst) * ADDR_W'(WORD_BYTES);
                issued_q <= issued_q + CNT_W'(burst);
            end
            if (frame_start && state != IDLE)        err_overrun  <= 1'b1;
            if (avm.readdatavalid && !ready_src)     err_overflow <= 1'b1;
        end
    end

endmodule
